// File: rtl/execute_muldiv_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled into one port.
// The decode side (master) drives operands and control; the stage (slave) returns registered results.
interface execute_muldiv_if #(
    parameter int LEN          = 32,
    parameter int NB           = $clog2(LEN),
    parameter int LEN_EXEC_BUS = 14,
    parameter int LEN_MEM_BUS  = 9,
    parameter int LEN_WB_BUS   = 2
);
    logic [LEN-1:0]          in_pc_branch;
    logic [LEN-1:0]          in_reg1;
    logic [LEN-1:0]          in_reg2;
    logic [LEN-1:0]          in_sign_extend;
    logic [NB-1:0]           in_rs;
    logic [NB-1:0]           in_rt;
    logic [NB-1:0]           in_rd;
    logic [NB-1:0]           in_shamt;
    logic [LEN_EXEC_BUS-1:0] execute_bus;
    logic [LEN_MEM_BUS-1:0]  memory_bus;
    logic [LEN_WB_BUS-1:0]   writeBack_bus;
    logic                    register_write_3_4;
    logic                    register_write_4_5;
    logic [NB-1:0]           rd_3_4;
    logic [NB-1:0]           rd_4_5;
    logic [LEN-1:0]          in_mem_forw;
    logic [LEN-1:0]          in_wb_forw;
    logic                    flush;
    logic                    halt_flag_e;

    logic [LEN-1:0]          out_pc_branch;
    logic [LEN-1:0]          out_alu;
    logic [LEN-1:0]          out_reg2;
    logic                    zero_flag;
    logic [NB-1:0]           out_write_reg;
    logic [LEN_MEM_BUS-1:0]  memory_bus_out;
    logic [LEN_WB_BUS-1:0]   writeBack_bus_out;
    logic                    out_halt_flag_e;
    logic                    stall_e;
    logic                    md_busy;

    modport master (
        output in_pc_branch, in_reg1, in_reg2, in_sign_extend,
        output in_rs, in_rt, in_rd, in_shamt,
        output execute_bus, memory_bus, writeBack_bus,
        output register_write_3_4, register_write_4_5, rd_3_4, rd_4_5,
        output in_mem_forw, in_wb_forw, flush, halt_flag_e,
        input  out_pc_branch, out_alu, out_reg2, zero_flag, out_write_reg,
        input  memory_bus_out, writeBack_bus_out, out_halt_flag_e, stall_e, md_busy
    );

    modport slave (
        input  in_pc_branch, in_reg1, in_reg2, in_sign_extend,
        input  in_rs, in_rt, in_rd, in_shamt,
        input  execute_bus, memory_bus, writeBack_bus,
        input  register_write_3_4, register_write_4_5, rd_3_4, rd_4_5,
        input  in_mem_forw, in_wb_forw, flush, halt_flag_e,
        output out_pc_branch, out_alu, out_reg2, zero_flag, out_write_reg,
        output memory_bus_out, writeBack_bus_out, out_halt_flag_e, stall_e, md_busy
    );
endinterface

// File: rtl/execute_muldiv.sv
// Pipelined MIPS execute stage: forwarding, ALU, iterative mul/div with HI/LO, EX/MEM register.
// ALU op codes: 0 SLL, 1 SRL, 2 SRA (B shifted by A), 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 LUI; others yield 0.
module execute_muldiv #(
    parameter int LEN          = 32,
    parameter int NB           = $clog2(LEN),
    parameter int LEN_EXEC_BUS = 14,
    parameter int LEN_MEM_BUS  = 9,
    parameter int LEN_WB_BUS   = 2
) (
    input logic             clk,
    input logic             reset,
    execute_muldiv_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0]    MD_MULT   = 3'd1;
    localparam logic [2:0]    MD_MULTU  = 3'd2;
    localparam logic [2:0]    MD_DIV    = 3'd3;
    localparam logic [2:0]    MD_DIVU   = 3'd4;
    localparam logic [2:0]    MD_MFHI   = 3'd5;
    localparam logic [2:0]    MD_MFLO   = 3'd6;
    localparam logic [NB-1:0] LAST_STEP = NB'(LEN - 1);
    localparam logic [NB-1:0] LINK_REG  = NB'(31);

    logic [3:0] alu_op;
    logic       imm_sel, shamt_sel, dest_rd, dest_ra, link;
    logic [2:0] mdop;

    assign alu_op    = bus.execute_bus[3:0];
    assign imm_sel   = bus.execute_bus[6];
    assign shamt_sel = bus.execute_bus[7];
    assign dest_rd   = bus.execute_bus[8];
    assign dest_ra   = bus.execute_bus[9];
    assign link      = bus.execute_bus[10];
    assign mdop      = bus.execute_bus[13:11];

    // ---------------- forwarding (0 = rs/A, 1 = rt/B) ----------------
    logic [NB-1:0]  src_idx [2];
    logic [LEN-1:0] src_val [2];
    logic [LEN-1:0] fwd     [2];

    assign src_idx[0] = bus.in_rs;
    assign src_idx[1] = bus.in_rt;
    assign src_val[0] = bus.in_reg1;
    assign src_val[1] = bus.in_reg2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_mem, hit_wb;
            assign hit_mem = bus.register_write_3_4 && (bus.rd_3_4 != '0) && (bus.rd_3_4 == src_idx[gi]);
            assign hit_wb  = bus.register_write_4_5 && (bus.rd_4_5 != '0) && (bus.rd_4_5 == src_idx[gi]);
            assign fwd[gi] = hit_mem ? bus.in_mem_forw : (hit_wb ? bus.in_wb_forw : src_val[gi]);
        end
    endgenerate

    logic [LEN-1:0] op_a, op_b;
    assign op_a = link ? bus.in_pc_branch : (shamt_sel ? LEN'(bus.in_shamt) : fwd[0]);
    assign op_b = link ? LEN'(1)          : (imm_sel   ? bus.in_sign_extend : fwd[1]);

    // ---------------- ALU ----------------
    logic [NB-1:0]  sh_amt;
    logic [LEN-1:0] alu_result;
    assign sh_amt = op_a[NB-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0:    alu_result = op_b << sh_amt;
            4'd1:    alu_result = op_b >> sh_amt;
            4'd2:    alu_result = $signed(op_b) >>> sh_amt;
            4'd3:    alu_result = op_a + op_b;
            4'd4:    alu_result = op_a - op_b;
            4'd5:    alu_result = op_a & op_b;
            4'd6:    alu_result = op_a | op_b;
            4'd7:    alu_result = op_a ^ op_b;
            4'd8:    alu_result = ~(op_a | op_b);
            4'd9:    alu_result = {{(LEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd10:   alu_result = {{(LEN-1){1'b0}}, (op_a < op_b)};
            4'd11:   alu_result = op_b << (LEN / 2);
            default: alu_result = '0;
        endcase
    end

    // ---------------- multiply / divide unit ----------------
    state_t            state_q, state_d;
    logic [NB-1:0]     cnt_q, cnt_d;
    logic [2*LEN-1:0]  work_q, work_d;
    logic [LEN-1:0]    divisor_q, divisor_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic [LEN-1:0]    hi_q, hi_d;
    logic [LEN-1:0]    lo_q, lo_d;

    logic is_start, is_signed, sign_a, sign_b, stall_e, start_ok;
    assign is_start  = (mdop == MD_MULT) || (mdop == MD_MULTU) || (mdop == MD_DIV) || (mdop == MD_DIVU);
    assign is_signed = (mdop == MD_MULT) || (mdop == MD_DIV);
    assign sign_a    = is_signed && fwd[0][LEN-1];
    assign sign_b    = is_signed && fwd[1][LEN-1];
    assign stall_e   = (state_q == BUSY) && (mdop >= MD_MULT) && (mdop <= MD_MFLO);
    assign start_ok  = (state_q == IDLE) && is_start && !stall_e && !bus.flush;

    // work_q holds {HI accumulator / remainder, multiplier / dividend-quotient}.
    logic [LEN:0]     mul_sum;
    logic [LEN:0]     div_rsh;
    logic [LEN+1:0]   div_trial;
    logic             div_ok;
    logic [2*LEN-1:0] step_work, prod_fix;
    logic [LEN-1:0]   quo_mag, rem_mag;

    assign mul_sum   = {1'b0, work_q[2*LEN-1:LEN]} + (work_q[0] ? {1'b0, divisor_q} : '0);
    assign div_rsh   = work_q[2*LEN-1:LEN-1];
    assign div_trial = {1'b0, div_rsh} - {2'b00, divisor_q};
    assign div_ok    = !div_trial[LEN+1];
    assign step_work = is_div_q
                     ? {(div_ok ? div_trial[LEN-1:0] : div_rsh[LEN-1:0]), work_q[LEN-2:0], div_ok}
                     : {mul_sum, work_q[LEN-1:1]};
    assign prod_fix  = neg_q ? -step_work : step_work;
    assign quo_mag   = step_work[LEN-1:0];
    assign rem_mag   = step_work[2*LEN-1:LEN];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    work_d    = {{LEN{1'b0}}, (sign_a ? -fwd[0] : fwd[0])};
                    divisor_d = sign_b ? -fwd[1] : fwd[1];
                    is_div_d  = (mdop == MD_DIV) || (mdop == MD_DIVU);
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div0_d    = (fwd[1] == '0);
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                work_d = step_work;
                cnt_d  = cnt_q + NB'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = IDLE;
                    if (is_div_q) begin
                        // Divide by zero: quotient forced to all ones, remainder falls out as the dividend.
                        lo_d = div0_q ? '1 : (neg_q ? -quo_mag : quo_mag);
                        hi_d = neg_rem_q ? -rem_mag : rem_mag;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- EX/MEM register ----------------
    logic [LEN-1:0]         result;
    logic [LEN-1:0]         out_pc_branch_q, out_pc_branch_d;
    logic [LEN-1:0]         out_alu_q, out_alu_d;
    logic [LEN-1:0]         out_reg2_q, out_reg2_d;
    logic                   zero_flag_q, zero_flag_d;
    logic [NB-1:0]          out_write_reg_q, out_write_reg_d;
    logic [LEN_MEM_BUS-1:0] memory_bus_out_q, memory_bus_out_d;
    logic [LEN_WB_BUS-1:0]  writeBack_bus_out_q, writeBack_bus_out_d;
    logic                   out_halt_flag_e_q, out_halt_flag_e_d;

    assign result = (mdop == MD_MFHI) ? hi_q : ((mdop == MD_MFLO) ? lo_q : alu_result);

    always_comb begin
        out_pc_branch_d     = bus.in_pc_branch + bus.in_sign_extend;
        out_alu_d           = result;
        out_reg2_d          = bus.in_reg2;
        zero_flag_d         = (result == '0);
        out_write_reg_d     = dest_ra ? LINK_REG : (dest_rd ? bus.in_rd : bus.in_rt);
        memory_bus_out_d    = bus.memory_bus;
        writeBack_bus_out_d = bus.writeBack_bus;
        out_halt_flag_e_d   = bus.halt_flag_e;
        if (bus.flush) begin
            out_pc_branch_d     = '0;
            out_alu_d           = '0;
            out_reg2_d          = '0;
            zero_flag_d         = 1'b0;
            out_write_reg_d     = '0;
            memory_bus_out_d    = '0;
            writeBack_bus_out_d = '0;
        end else if (stall_e) begin
            // Bubble: the held instruction is re-presented once the unit frees up.
            memory_bus_out_d    = '0;
            writeBack_bus_out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            work_q              <= '0;
            divisor_q           <= '0;
            is_div_q            <= 1'b0;
            neg_q               <= 1'b0;
            neg_rem_q           <= 1'b0;
            div0_q              <= 1'b0;
            hi_q                <= '0;
            lo_q                <= '0;
            out_pc_branch_q     <= '0;
            out_alu_q           <= '0;
            out_reg2_q          <= '0;
            zero_flag_q         <= 1'b0;
            out_write_reg_q     <= '0;
            memory_bus_out_q    <= '0;
            writeBack_bus_out_q <= '0;
            out_halt_flag_e_q   <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            work_q              <= work_d;
            divisor_q           <= divisor_d;
            is_div_q            <= is_div_d;
            neg_q               <= neg_d;
            neg_rem_q           <= neg_rem_d;
            div0_q              <= div0_d;
            hi_q                <= hi_d;
            lo_q                <= lo_d;
            out_pc_branch_q     <= out_pc_branch_d;
            out_alu_q           <= out_alu_d;
            out_reg2_q          <= out_reg2_d;
            zero_flag_q         <= zero_flag_d;
            out_write_reg_q     <= out_write_reg_d;
            memory_bus_out_q    <= memory_bus_out_d;
            writeBack_bus_out_q <= writeBack_bus_out_d;
            out_halt_flag_e_q   <= out_halt_flag_e_d;
        end
    end

    assign bus.out_pc_branch     = out_pc_branch_q;
    assign bus.out_alu           = out_alu_q;
    assign bus.out_reg2          = out_reg2_q;
    assign bus.zero_flag         = zero_flag_q;
    assign bus.out_write_reg     = out_write_reg_q;
    assign bus.memory_bus_out    = memory_bus_out_q;
    assign bus.writeBack_bus_out = writeBack_bus_out_q;
    assign bus.out_halt_flag_e   = out_halt_flag_e_q;
    assign bus.stall_e           = stall_e;
    assign bus.md_busy           = (state_q == BUSY);

    logic unused_bits;
    assign unused_bits = ^{bus.execute_bus[5:4], div_trial[LEN]};
endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed bench for execute_muldiv against a cycle-level arithmetic model.
module tb_execute_muldiv;
    localparam int LEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_muldiv_if #(.LEN(LEN)) bus ();
    execute_muldiv #(.LEN(LEN)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // model state: cycles of BUSY left, architected HI/LO, pending result
    int          md_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        stall_seen = 1'b0;
    int          txn_no = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return b << a[4:0];
            4'd1:    return b >> a[4:0];
            4'd2:    return $signed(b) >>> a[4:0];
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~(a | b);
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   return (a < b) ? 32'd1 : 32'd0;
            4'd11:   return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        hi = '0;
        lo = '0;
        case (md)
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; {hi, lo} = p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
            3'd3: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] idx, input logic [31:0] regv);
        if (bus.register_write_3_4 && bus.rd_3_4 != 0 && bus.rd_3_4 == idx) return bus.in_mem_forw;
        if (bus.register_write_4_5 && bus.rd_4_5 != 0 && bus.rd_4_5 == idx) return bus.in_wb_forw;
        return regv;
    endfunction

    // One clock of the stage: check the combinational stall, clock, then check EX/MEM.
    task automatic step();
        logic [2:0]  md;
        logic [31:0] fa, fb, a, b, res, e_pcb, e_reg2;
        logic [4:0]  e_wr;
        logic [8:0]  e_mem;
        logic [1:0]  e_wb;
        logic        e_stall, fl, hl;
        #1;
        md      = bus.execute_bus[13:11];
        fa      = fwd_ref(bus.in_rs, bus.in_reg1);
        fb      = fwd_ref(bus.in_rt, bus.in_reg2);
        a       = bus.execute_bus[10] ? bus.in_pc_branch : (bus.execute_bus[7] ? 32'(bus.in_shamt) : fa);
        b       = bus.execute_bus[10] ? 32'd1 : (bus.execute_bus[6] ? bus.in_sign_extend : fb);
        res     = (md == 3'd5) ? m_hi : ((md == 3'd6) ? m_lo : alu_ref(bus.execute_bus[3:0], a, b));
        e_pcb   = bus.in_pc_branch + bus.in_sign_extend;
        e_reg2  = bus.in_reg2;
        e_wr    = bus.execute_bus[9] ? 5'd31 : (bus.execute_bus[8] ? bus.in_rd : bus.in_rt);
        e_mem   = bus.memory_bus;
        e_wb    = bus.writeBack_bus;
        fl      = bus.flush;
        hl      = bus.halt_flag_e;
        e_stall = (md_left > 0) && (md >= 3'd1) && (md <= 3'd6);
        check_eq("stall_e", bus.stall_e, e_stall);
        stall_seen = bus.stall_e;

        @(posedge clk);
        #1;
        if (md_left > 0) begin
            md_left--;
            if (md_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (md >= 3'd1 && md <= 3'd4 && !fl) begin
            md_left = LEN;
            md_ref(md, fa, fb, p_hi, p_lo);
        end

        check_eq("halt", bus.out_halt_flag_e, hl);
        if (fl) begin
            check_eq("flush_data", {bus.out_alu, bus.out_pc_branch}, 64'd0);
            check_eq("flush_ctl", {bus.out_reg2, bus.zero_flag, bus.out_write_reg,
                                   bus.memory_bus_out, bus.writeBack_bus_out}, 64'd0);
        end else if (e_stall) begin
            check_eq("bubble", {bus.memory_bus_out, bus.writeBack_bus_out}, 64'd0);
        end else begin
            check_eq("alu", bus.out_alu, res);
            check_eq("pc_branch", bus.out_pc_branch, e_pcb);
            check_eq("reg2", bus.out_reg2, e_reg2);
            check_eq("ctl", {bus.zero_flag, bus.out_write_reg, bus.memory_bus_out, bus.writeBack_bus_out},
                     {res == 0, e_wr, e_mem, e_wb});
        end
        check_eq("md_busy", bus.md_busy, md_left > 0);
        $display("txn %0d md=%0d op=%0d flush=%0b stall=%0b out_alu=%08h busy=%0b",
                 txn_no, md, bus.execute_bus[3:0], fl, e_stall, bus.out_alu, bus.md_busy);
        txn_no++;
    endtask

    task automatic set_nop();
        bus.in_pc_branch = '0; bus.in_reg1 = '0; bus.in_reg2 = '0; bus.in_sign_extend = '0;
        bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_shamt = '0;
        bus.execute_bus = 14'd3;
        bus.memory_bus = '0; bus.writeBack_bus = '0;
        bus.register_write_3_4 = 1'b0; bus.register_write_4_5 = 1'b0;
        bus.rd_3_4 = '0; bus.rd_4_5 = '0; bus.in_mem_forw = '0; bus.in_wb_forw = '0;
        bus.flush = 1'b0; bus.halt_flag_e = 1'b0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2);
        set_nop();
        bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_reg1 = r1; bus.in_reg2 = r2;
        bus.execute_bus[3:0] = op;
        bus.writeBack_bus = 2'b10;
    endtask

    task automatic set_md(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
        set_alu(4'd3, a, b);
        bus.execute_bus[13:11] = md;
    endtask

    // Present MFHI/MFLO and hold it until it is no longer stalled.
    task automatic run_mf(input logic [2:0] md, output int stalls);
        stalls = 0;
        set_md(md, 32'd0, 32'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (!stall_seen) break;
            stalls++;
        end
        check_eq("mf_done", stall_seen, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < LEN + 2 && md_left > 0; i++) begin
            set_nop();
            step();
        end
        check_eq("idle_reached", bus.md_busy, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_data"}, {bus.out_alu, bus.out_pc_branch}, 64'd0);
        check_eq({tag, "_ctl"}, {bus.out_reg2, bus.zero_flag, bus.out_write_reg, bus.memory_bus_out,
                                 bus.writeBack_bus_out, bus.out_halt_flag_e, bus.md_busy}, 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs();
        logic [2:0] md;
        md = ($urandom_range(0, 9) < 5) ? 3'd0 : 3'($urandom_range(1, 7));
        bus.in_pc_branch = $urandom; bus.in_sign_extend = $urandom;
        bus.in_reg1 = pick_operand(); bus.in_reg2 = pick_operand();
        bus.in_rs = 5'($urandom_range(0, 7)); bus.in_rt = 5'($urandom_range(0, 7));
        bus.in_rd = 5'($urandom); bus.in_shamt = 5'($urandom);
        bus.execute_bus = {md, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom_range(0, 12))};
        bus.memory_bus = 9'($urandom); bus.writeBack_bus = 2'($urandom);
        bus.register_write_3_4 = 1'($urandom); bus.register_write_4_5 = 1'($urandom);
        bus.rd_3_4 = 5'($urandom_range(0, 7)); bus.rd_4_5 = 5'($urandom_range(0, 7));
        bus.in_mem_forw = $urandom; bus.in_wb_forw = $urandom;
        bus.flush = ($urandom_range(0, 9) == 0);
        bus.halt_flag_e = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int stalls;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_init");
        rst_n = 1'b1;

        // MULTU 0xFFFFFFFF x 2
        set_md(3'd2, 32'hFFFF_FFFF, 32'd2);
        step();
        run_mf(3'd5, stalls);
        check_eq("mfhi_stalls", stalls, 32);
        check_eq("multu_hi", bus.out_alu, 32'h0000_0001);
        run_mf(3'd6, stalls);
        check_eq("mflo_stalls", stalls, 0);
        check_eq("multu_lo", bus.out_alu, 32'hFFFF_FFFE);

        // DIV -7/2 and DIVU 5/0
        set_md(3'd3, 32'hFFFF_FFF9, 32'd2);
        step();
        run_mf(3'd6, stalls);
        check_eq("div_lo", bus.out_alu, 32'hFFFF_FFFD);
        run_mf(3'd5, stalls);
        check_eq("div_hi", bus.out_alu, 32'hFFFF_FFFF);
        set_md(3'd4, 32'd5, 32'd0);
        step();
        run_mf(3'd6, stalls);
        check_eq("divu0_lo", bus.out_alu, 32'hFFFF_FFFF);
        run_mf(3'd5, stalls);
        check_eq("divu0_hi", bus.out_alu, 32'd5);

        // forwarding priority and the r0 exclusion
        set_alu(4'd3, 32'd100, 32'd1);
        bus.in_rs = 5'd3; bus.rd_3_4 = 5'd3; bus.rd_4_5 = 5'd3;
        bus.register_write_3_4 = 1'b1; bus.register_write_4_5 = 1'b1;
        bus.in_mem_forw = 32'd10; bus.in_wb_forw = 32'd20;
        step();
        check_eq("fwd_mem", bus.out_alu, 32'd11);
        bus.register_write_3_4 = 1'b0;
        step();
        check_eq("fwd_wb", bus.out_alu, 32'd21);
        bus.register_write_3_4 = 1'b1;
        bus.in_rs = 5'd0; bus.rd_3_4 = 5'd0; bus.rd_4_5 = 5'd0;
        step();
        check_eq("fwd_r0", bus.out_alu, 32'd101);

        // non-md op while busy, then flushed start
        set_md(3'd1, 32'd7, 32'd6);
        step();
        set_alu(4'd4, 32'd50, 32'd8);
        step();
        check_eq("sub_while_busy", bus.out_alu, 32'd42);
        check_eq("busy_during_sub", bus.md_busy, 1'b1);
        wait_idle();
        set_md(3'd1, 32'd3, 32'd3);
        bus.flush = 1'b1;
        step();
        check_eq("flush_no_start", bus.md_busy, 1'b0);

        // JAL link, then halt propagating through a stall
        set_nop();
        bus.in_pc_branch = 32'h100;
        bus.execute_bus[10] = 1'b1;
        bus.execute_bus[9] = 1'b1;
        step();
        check_eq("jal_alu", bus.out_alu, 32'h101);
        check_eq("jal_wr", bus.out_write_reg, 5'd31);
        set_md(3'd1, 32'hFFFF_FFFB, 32'd5);
        step();
        set_md(3'd6, 32'd0, 32'd0);
        bus.halt_flag_e = 1'b1;
        step();
        check_eq("stalled_with_halt", stall_seen, 1'b1);
        check_eq("halt_while_stalled", bus.out_halt_flag_e, 1'b1);
        run_mf(3'd6, stalls);
        check_eq("mult_neg_lo", bus.out_alu, 32'hFFFF_FFE7);

        // asynchronous reset in the middle of a MULT
        set_md(3'd1, 32'd9, 32'd9);
        step();
        set_alu(4'd3, 32'd5, 32'd6);
        bus.halt_flag_e = 1'b1;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        check_reset("rst_held");
        rst_n = 1'b1;
        md_left = 0; m_hi = '0; m_lo = '0;
        run_mf(3'd6, stalls);
        check_eq("rst_mflo_stalls", stalls, 0);
        check_eq("rst_mflo_val", bus.out_alu, 32'd0);

        // random traffic; a stalled instruction is held by upstream
        for (int t = 0; t < 600; t++) begin
            if (!stall_seen) begin
                randomize_inputs();
            end else begin
                bus.flush = ($urandom_range(0, 7) == 0);
                bus.halt_flag_e = 1'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
